// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_REDIR
  } fetch_state_t;

  localparam logic [31:0] INSTR_BYTES   = 32'd4;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  // Redirect target wraps modulo 2^32 and is forced to word alignment.
  function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [31:0] imm);
    return (pc + imm) & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory port: valid/ready read request plus in-order valid response.
interface instr_fetch_if;

  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (output req_valid, req_addr, input req_ready, rsp_valid, rsp_data);
  modport slave  (input req_valid, req_addr, output req_ready, rsp_valid, rsp_data);

endinterface

// File: rtl/fetch_fifo.sv
// Small circular instruction queue; flush wins over a same-cycle push.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // A pop in the same cycle frees the slot, so a full queue may still accept a push.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, keeps memory reads within queue credit, and
// redirects on taken branches while discarding wrong-path responses.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master imem,
  output logic [31:0]   instr,
  output logic [31:0]   instr_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic          PCsrc,
  input  logic [31:0]   ImmOp
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(BUF_DEPTH);

  fetch_state_t  state, state_next;
  logic [31:0]   fetch_pc, head_pc, instr_last, fifo_head, target;
  logic [CW-1:0] outstanding, drop_cnt, occupancy;
  logic [CW:0]   in_use;
  logic          consume, redirect, req_valid, req_fire;
  logic          rsp_keep, rsp_drop, fifo_empty, fifo_full;

  assign consume  = instr_valid & instr_ready;
  assign redirect = consume & PCsrc;
  assign target   = branch_target(head_pc, ImmOp);
  assign in_use   = {1'b0, outstanding} + {1'b0, occupancy};
  assign rsp_drop = imem.rsp_valid & (drop_cnt != '0);
  assign rsp_keep = imem.rsp_valid & (drop_cnt == '0);
  assign req_fire = req_valid & imem.req_ready;

  assign imem.req_valid = req_valid;
  assign imem.req_addr  = fetch_pc;

  // Requests only while every in-flight word is guaranteed a queue slot.
  always_comb begin
    state_next = state;
    req_valid  = 1'b0;
    case (state)
      S_BOOT:  state_next = S_RUN;
      S_RUN: begin
        req_valid = (in_use < DEPTH_C) && !redirect;
        if (redirect) state_next = S_REDIR;
      end
      S_REDIR: state_next = S_RUN;
      default: state_next = S_BOOT;
    endcase
  end

  // On redirect every request still in flight after this cycle is stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_BOOT;
      fetch_pc    <= RESET_PC;
      head_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      instr_last  <= NOP_INSTR;
    end else begin
      state       <= state_next;
      outstanding <= outstanding + CW'(req_fire) - CW'(imem.rsp_valid);
      if (instr_valid) instr_last <= fifo_head;
      if (redirect) begin
        fetch_pc <= target;
        head_pc  <= target;
        drop_cnt <= outstanding - CW'(imem.rsp_valid);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + INSTR_BYTES;
        if (consume)  head_pc  <= head_pc + INSTR_BYTES;
        if (rsp_drop) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  fetch_fifo #(
    .DEPTH(BUF_DEPTH),
    .WIDTH(32)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (rsp_keep),
    .pop  (consume),
    .flush(redirect),
    .din  (imem.rsp_data),
    .dout (fifo_head),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(occupancy)
  );

  assign instr_valid = ~fifo_empty;
  assign instr       = instr_valid ? fifo_head : instr_last;
  assign instr_pc    = head_pc;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(rsp_keep && fifo_full && !consume && !redirect));

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized scoreboard bench for instr_fetch: an architectural PC model
// predicts the instruction stream decode must see.
module tb_instr_fetch;
  import fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr, instr_pc, ImmOp;
  logic        instr_valid, instr_ready, PCsrc;

  instr_fetch_if imem ();

  instr_fetch #(
    .RESET_PC (RESET_PC),
    .BUF_DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem       (imem),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .PCsrc      (PCsrc),
    .ImmOp      (ImmOp)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;

  exp_t        exp_q[$];
  pend_t       pend_q[$];
  int          checks = 0, passed = 0, cyc = 0, last_due = 0, consumed = 0, accepted = 0;
  int          ready_pct, lat_min, lat_max, take_pct, br_pct;
  logic        force_en = 1'b0;
  logic [31:0] force_pc, force_imm, model_pc;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_addr;

  // Odd multiplier makes every word address map to a distinct instruction.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return addr * 32'h9E37_79B1 + 32'h1234_5677;
  endfunction

  function automatic logic [31:0] pick_imm();
    logic [31:0] v;
    case ($urandom_range(0, 4))
      0:       v = 32'hFFFF_FFF8;
      1:       v = 32'h0000_0007;
      2:       v = 32'hFFFF_FFFC;
      3:       v = 32'h0000_0040;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("[TB] FAIL %s: got %h, required %h", name, act, req);
  endtask

  task automatic check_reset(input string tag);
    checkOutput({tag, "_req_valid"},   {31'b0, imem.req_valid}, 32'd0);
    checkOutput({tag, "_req_addr"},    imem.req_addr,           RESET_PC);
    checkOutput({tag, "_instr_valid"}, {31'b0, instr_valid},    32'd0);
    checkOutput({tag, "_instr"},       instr,                   NOP_INSTR);
    checkOutput({tag, "_instr_pc"},    instr_pc,                RESET_PC);
  endtask

  task automatic init_model();
    exp_q.delete();
    pend_q.delete();
    model_pc  = RESET_PC;
    exp_q.push_back('{pc: RESET_PC, data: mem_word(RESET_PC)});
    last_due  = cyc;
    prev_hold = 1'b0;
    accepted  = 0;
  endtask

  function automatic int next_due();
    int d;
    d = cyc + int'($urandom_range(lat_min, lat_max));
    if (d <= last_due) d = last_due + 1;
    last_due = d;
    return d;
  endfunction

  // One cycle of memory response, decode handshake and branch decision;
  // every consume pushes the architecturally next instruction.
  task automatic applyStimulus();
    logic [31:0] nxt;
    @(negedge clk);
    cyc++;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem.rsp_valid = 1'b1;
      imem.rsp_data  = mem_word(pend_q[0].addr);
      void'(pend_q.pop_front());
    end else begin
      imem.rsp_valid = 1'b0;
      imem.rsp_data  = $urandom;
    end
    imem.req_ready = ($urandom_range(0, 99) < ready_pct);
    instr_ready    = ($urandom_range(0, 99) < take_pct);
    PCsrc          = 1'($urandom_range(0, 1));
    ImmOp          = $urandom;
    if (instr_valid && instr_ready) begin
      if (force_en && model_pc == force_pc) begin
        PCsrc    = 1'b1;
        ImmOp    = force_imm;
        force_en = 1'b0;
      end else begin
        PCsrc = ($urandom_range(0, 99) < br_pct);
        ImmOp = pick_imm();
      end
      nxt = PCsrc ? ((model_pc + ImmOp) & 32'hFFFF_FFFC) : model_pc + 32'd4;
      exp_q.push_back('{pc: nxt, data: mem_word(nxt)});
      model_pc = nxt;
    end
  endtask

  task automatic run_until_force(input int budget);
    for (int i = 0; i < budget && force_en; i++) applyStimulus();
    checkOutput("force_reached", {31'b0, force_en}, 32'd0);
  endtask

  // Monitor: memory acceptance, request stability and decode-side scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold && !(instr_valid && instr_ready && PCsrc)) begin
          checkOutput("req_hold_valid", {31'b0, imem.req_valid}, 32'd1);
          checkOutput("req_hold_addr", imem.req_addr, prev_addr);
        end
        prev_hold = imem.req_valid && !imem.req_ready;
        prev_addr = imem.req_addr;
        if (imem.req_valid && imem.req_ready) begin
          checkOutput("req_align", imem.req_addr & 32'h3, 32'h0);
          pend_q.push_back('{addr: imem.req_addr, due: next_due()});
          accepted++;
        end
        if (instr_valid && instr_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("[TB] FAIL unexpected_instr: got pc %h, required none", instr_pc);
          end else begin
            e = exp_q.pop_front();
            checkOutput("instr_pc", instr_pc, e.pc);
            checkOutput("instr", instr, e.data);
          end
          consumed++;
        end
      end
    end
  end

  initial begin
    int base;
    imem.req_ready = 1'b0;
    imem.rsp_valid = 1'b0;
    imem.rsp_data  = '0;
    instr_ready    = 1'b0;
    PCsrc          = 1'b0;
    ImmOp          = '0;
    ready_pct = 100; lat_min = 1; lat_max = 1; take_pct = 100; br_pct = 0;

    repeat (3) @(negedge clk);
    #1;
    check_reset("por");
    #1;
    init_model();
    rst = 1'b0;

    // Fetch latency from reset, then decode stalls until the queue fills.
    applyStimulus(); #2;
    checkOutput("first_req_valid", {31'b0, imem.req_valid}, 32'd1);
    checkOutput("first_req_addr", imem.req_addr, RESET_PC);
    take_pct = 0;
    applyStimulus(); #2;
    checkOutput("cyc2_instr_valid", {31'b0, instr_valid}, 32'd0);
    applyStimulus(); #2;
    checkOutput("cyc3_instr_valid", {31'b0, instr_valid}, 32'd1);
    checkOutput("cyc3_instr_pc", instr_pc, RESET_PC);
    checkOutput("cyc3_instr", instr, mem_word(RESET_PC));
    repeat (10) applyStimulus();
    #2;
    checkOutput("stall_accepted", accepted, 32'd2);
    checkOutput("stall_req_valid", {31'b0, imem.req_valid}, 32'd0);
    checkOutput("stall_instr_valid", {31'b0, instr_valid}, 32'd1);

    // Backward branch at 0x10 while a request is in flight.
    force_en = 1'b1; force_pc = 32'h10; force_imm = 32'hFFFF_FFF8; take_pct = 100;
    run_until_force(60);
    repeat (20) applyStimulus();

    // Memory back-pressure, misaligned offset, then a wrap-around target.
    ready_pct = 0;
    repeat (6) applyStimulus();
    ready_pct = 100;
    force_en = 1'b1; force_pc = model_pc; force_imm = 32'h7;
    run_until_force(60);
    force_en = 1'b1; force_pc = model_pc; force_imm = 32'hFFFF_FFFC - model_pc;
    run_until_force(60);
    force_en = 1'b1; force_pc = 32'hFFFF_FFFC; force_imm = 32'h8;
    run_until_force(60);
    repeat (20) applyStimulus();

    ready_pct = 70; lat_min = 1; lat_max = 4; take_pct = 70; br_pct = 20;
    base = consumed;
    repeat (400) applyStimulus();
    checkOutput("random_progress", {31'b0, (consumed - base) >= 20}, 32'd1);

    // Asynchronous reset with long-latency reads in flight.
    ready_pct = 100; lat_min = 6; lat_max = 6; take_pct = 0; br_pct = 0;
    repeat (3) applyStimulus();
    @(posedge clk);
    #2;
    rst = 1'b1;
    imem.rsp_valid = 1'b0;
    imem.req_ready = 1'b0;
    instr_ready    = 1'b0;
    #1;
    check_reset("mid");
    @(negedge clk);
    @(negedge clk);
    #2;
    init_model();
    rst = 1'b0;
    ready_pct = 70; lat_min = 1; lat_max = 3; take_pct = 80; br_pct = 15;
    base = consumed;
    repeat (250) applyStimulus();
    checkOutput("restart_progress", {31'b0, (consumed - base) >= 20}, 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
